// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB 1.1 transmit-side arbiter.
package usb_tx_pkg;

    localparam int BYTE_W   = 8;
    localparam int REQ_HS   = 0;
    localparam int REQ_DATA = 1;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SEND,
        EOP_WAIT,
        GAP
    } state_e;

endpackage

// File: rtl/usb_tx_rr_pick.sv
// Two-way request selector: single requests win outright, a tie goes to the requester named by ptr.
module usb_tx_rr_pick
    import usb_tx_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        if (req[REQ_HS] && req[REQ_DATA]) begin
            if (ptr) begin
                win[REQ_DATA] = 1'b1;
            end else begin
                win[REQ_HS] = 1'b1;
            end
        end else begin
            win = req;
        end
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Shares the USB 1.1 PHY transmit path between a handshake/token requester and a data requester.
// Define USB_TX_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 always wins ties.
module usb_tx_arbiter
    import usb_tx_pkg::*;
#(
    parameter int GAP_CLKS  = 16,
    parameter int MAX_STALL = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_i,
    input  logic [BYTE_W-1:0] data0_i,
    input  logic [BYTE_W-1:0] data1_i,
    input  logic [1:0]        valid_i,
    input  logic [1:0]        last_i,
    output logic [1:0]        ready_o,
    output logic [1:0]        gnt_o,
    input  logic              rx_active_i,
    output logic [BYTE_W-1:0] phy_data_o,
    output logic              phy_valid_o,
    input  logic              phy_ready_i,
    output logic              phy_last_o,
    input  logic              phy_eop_done_i,
    output logic              phy_oe_o,
    output logic              phy_abort_o,
    output logic              busy_o
);

    localparam int STALL_W = $clog2(MAX_STALL + 1);
    localparam int GAP_W   = $clog2(GAP_CLKS + 1);

    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(MAX_STALL);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(MAX_STALL - 1);
    localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(GAP_CLKS - 1);

    state_e             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic              rr_ptr;
    logic [1:0]        winner;
    logic              g_idx;
    logic              g_req;
    logic              g_valid;
    logic              g_last;
    logic [BYTE_W-1:0] g_data;
    logic              xfer;
    logic              stall_expire;

    function automatic logic [STALL_W-1:0] stall_inc(input logic [STALL_W-1:0] c);
        return (c == STALL_MAX) ? c : c + STALL_W'(1);
    endfunction

    function automatic logic [GAP_W-1:0] gap_dec(input logic [GAP_W-1:0] c);
        return (c == '0) ? c : c - GAP_W'(1);
    endfunction

    usb_tx_rr_pick u_pick (
        .req (req_i),
        .ptr (rr_ptr),
        .win (winner)
    );

`ifdef USB_TX_ARB_RR_EN
    logic rr_ptr_q, rr_ptr_d;

    // After every packet that reaches GAP, prefer the requester that did not just own the bus.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q != GAP && state_d == GAP) begin
            rr_ptr_d = ~g_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = 1'b0;
`endif

    // Granted-requester view: gnt_q is one-hot, so bit 1 alone names the owner.
    assign g_idx   = gnt_q[REQ_DATA];
    assign g_req   = req_i[g_idx];
    assign g_valid = valid_i[g_idx];
    assign g_last  = last_i[g_idx];
    assign g_data  = g_idx ? data1_i : data0_i;

    assign xfer         = (state_q == SEND) && g_valid && phy_ready_i;
    assign stall_expire = (state_q == SEND) && !g_valid && (stall_q == STALL_LAST);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        stall_d = stall_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if ((|req_i) && !rx_active_i) begin
                    gnt_d   = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                stall_d = '0;
                if (!g_req) begin
                    gnt_d   = 2'b00;
                    state_d = IDLE;
                end else begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (g_valid) begin
                    stall_d = '0;
                    if (xfer && g_last) begin
                        state_d = EOP_WAIT;
                    end
                end else if (stall_expire) begin
                    gnt_d   = 2'b00;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    stall_d = stall_inc(stall_q);
                end
            end
            EOP_WAIT: begin
                if (phy_eop_done_i) begin
                    gnt_d   = 2'b00;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_dec(gap_q);
                end
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            stall_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            stall_q <= stall_d;
            gap_q   <= gap_d;
        end
    end

    // Byte path is a straight pass-through while sending; everything is parked low otherwise.
    always_comb begin
        phy_data_o  = '0;
        phy_valid_o = 1'b0;
        phy_last_o  = 1'b0;
        ready_o     = 2'b00;
        if (state_q == SEND) begin
            phy_data_o  = g_data;
            phy_valid_o = g_valid;
            phy_last_o  = g_last;
            ready_o     = gnt_q & {2{phy_ready_i}};
        end
    end

    assign gnt_o       = gnt_q;
    assign phy_oe_o    = (state_q == GRANT) || (state_q == SEND) || (state_q == EOP_WAIT);
    assign phy_abort_o = stall_expire;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Randomized bench for usb_tx_arbiter: packet-level expectations derived from grant/stall/gap timing rules.
module tb_usb_tx_arbiter;

    localparam int GAP_CLKS  = 16;
    localparam int MAX_STALL = 64;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [1:0] req_i, valid_i, last_i, ready_o, gnt_o;
    logic [7:0] data0_i, data1_i, phy_data_o;
    logic       rx_active_i, phy_valid_o, phy_ready_i, phy_last_o;
    logic       phy_eop_done_i, phy_oe_o, phy_abort_o, busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    usb_tx_arbiter #(
        .GAP_CLKS  (GAP_CLKS),
        .MAX_STALL (MAX_STALL)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .data0_i        (data0_i),
        .data1_i        (data1_i),
        .valid_i        (valid_i),
        .last_i         (last_i),
        .ready_o        (ready_o),
        .gnt_o          (gnt_o),
        .rx_active_i    (rx_active_i),
        .phy_data_o     (phy_data_o),
        .phy_valid_o    (phy_valid_o),
        .phy_ready_i    (phy_ready_i),
        .phy_last_o     (phy_last_o),
        .phy_eop_done_i (phy_eop_done_i),
        .phy_oe_o       (phy_oe_o),
        .phy_abort_o    (phy_abort_o),
        .busy_o         (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_req(input int r, input logic v, input logic [7:0] d, input logic l);
        valid_i[r] = v;
        last_i[r]  = l;
        if (r == 0) data0_i = d;
        else        data1_i = d;
    endtask

    task automatic quiet_inputs();
        req_i = 2'b00; valid_i = 2'b00; last_i = 2'b00;
        data0_i = 8'h00; data1_i = 8'h00;
        rx_active_i = 1'b0; phy_ready_i = 1'b0; phy_eop_done_i = 1'b0;
    endtask

    // One packet from requester r, starting with the DUT idle. stall_k >= 0 withholds
    // byte stall_k forever so the watchdog must fire. Cycle 0 is the negedge req rises.
    task automatic run_packet(input int r, input int nbytes, input int stall_k,
                              input int rx_hold, input int eop_delay);
        logic [7:0] pkt[$];
        logic [1:0] oh;
        int o, g_cyc, c0, last_cyc, end_cyc, idx, gap_left;
        bit presenting, in_send, exp_abort, xfer_exp, spur, ended, granted, busy_exp;
        oh = (r == 0) ? 2'b01 : 2'b10;
        o  = 1 - r;
        for (int i = 0; i < nbytes; i++) pkt.push_back(8'($urandom));
        g_cyc = rx_hold + 1;
        c0 = g_cyc; last_cyc = -1; end_cyc = -1; idx = 0;
        gap_left = $urandom_range(0, 2);
        presenting = 1'b0; spur = 1'($urandom); ended = 1'b0;
        for (int cyc = 0; cyc <= 800 && !ended; cyc++) begin
            @(negedge clk);
            if (last_cyc >= 0 || end_cyc >= 0) begin
                req_i[r] = 1'b0;
                drive_req(r, 1'b0, 8'h00, 1'b0);
            end else begin
                req_i[r] = 1'b1;
                if (stall_k >= 0 && idx == stall_k) begin
                    drive_req(r, 1'b0, 8'h00, 1'b0);
                end else if (!presenting) begin
                    if (gap_left > 0) begin
                        gap_left--;
                        drive_req(r, 1'b0, 8'h00, 1'b0);
                    end else begin
                        presenting = 1'b1;
                        drive_req(r, 1'b1, pkt[idx], idx == nbytes - 1);
                    end
                end
            end
            drive_req(o, 1'($urandom), 8'($urandom), 1'($urandom));
            phy_ready_i = ($urandom_range(0, 3) != 0);
            rx_active_i = (cyc < rx_hold) ? 1'b1 :
                          (cyc > g_cyc && end_cyc < 0) ? 1'($urandom) : 1'b0;
            phy_eop_done_i = 1'b0;
            if (last_cyc >= 0 && end_cyc < 0 && cyc == last_cyc + eop_delay) begin
                phy_eop_done_i = 1'b1;
                end_cyc = cyc;
            end else if (spur && end_cyc >= 0 && cyc == end_cyc + 2) begin
                phy_eop_done_i = 1'b1;
            end
            #1;
            in_send   = (cyc > g_cyc) && (last_cyc < 0) && (end_cyc < 0);
            exp_abort = in_send && !valid_i[r] && (cyc - c0 == MAX_STALL);
            xfer_exp  = in_send && valid_i[r] && phy_ready_i;
            granted   = (cyc >= g_cyc) && (end_cyc < 0 || cyc <= end_cyc);
            busy_exp  = (cyc >= g_cyc) && (end_cyc < 0 || cyc <= end_cyc + GAP_CLKS);
            check("gnt",    gnt_o,       granted ? oh : 2'b00);
            check("oe",     phy_oe_o,    granted);
            check("busy",   busy_o,      busy_exp);
            check("ready",  ready_o,     (in_send && phy_ready_i) ? oh : 2'b00);
            check("pvalid", phy_valid_o, in_send && valid_i[r]);
            check("abort",  phy_abort_o, exp_abort);
            if (in_send && valid_i[r]) begin
                check("data", phy_data_o, pkt[idx]);
                check("last", phy_last_o, idx == nbytes - 1);
                c0 = cyc;
            end
            if (xfer_exp) begin
                presenting = 1'b0;
                gap_left = $urandom_range(0, 2);
                if (idx == nbytes - 1) last_cyc = cyc;
                idx++;
            end
            if (exp_abort) end_cyc = cyc;
            if (end_cyc >= 0 && cyc == end_cyc + GAP_CLKS + 1) ended = 1'b1;
        end
        if (!ended) check("pkt_timeout", 32'd0, 32'd1);
        quiet_inputs();
    endtask

    initial begin
        logic [1:0] exp_second;
        rst_i = 1'b1;
        quiet_inputs();
        repeat (2) @(negedge clk);
        check("rst_outs", {gnt_o, ready_o, phy_data_o, phy_valid_o, phy_last_o,
                           phy_oe_o, phy_abort_o, busy_o}, 32'd0);
        rst_i = 1'b0;

        run_packet(1, 3, -1, 0, 2);
        run_packet(0, 2, -1, 3, 1);
        run_packet(0, 2, 0, 0, 1);
        run_packet(1, 4, 2, 1, 3);

        // Simultaneous requests; requester 0 keeps requesting across the gap.
        @(negedge clk);
        req_i = 2'b11; phy_ready_i = 1'b1;
        @(negedge clk);
        check("both_gnt", gnt_o, 2'b01);
        valid_i[0] = 1'b1; last_i[0] = 1'b1; data0_i = 8'hA5;
        @(negedge clk);
        check("both_send", {phy_valid_o, phy_last_o, phy_data_o}, {1'b1, 1'b1, 8'hA5});
        @(negedge clk);
        check("both_eopw", {gnt_o, phy_oe_o, phy_valid_o}, {2'b01, 1'b1, 1'b0});
        valid_i = 2'b00; last_i = 2'b00; phy_eop_done_i = 1'b1;
        @(negedge clk);
        phy_eop_done_i = 1'b0;
        check("gap_entry", {gnt_o, phy_oe_o, busy_o}, {2'b00, 1'b0, 1'b1});
        repeat (GAP_CLKS - 1) @(negedge clk);
        check("gap_hold", {gnt_o, busy_o}, {2'b00, 1'b1});
        @(negedge clk);
        check("gap_done", {gnt_o, busy_o}, 3'b000);
        @(negedge clk);
`ifdef USB_TX_ARB_RR_EN
        exp_second = 2'b10;
`else
        exp_second = 2'b01;
`endif
        check("second_gnt", gnt_o, exp_second);
        req_i = 2'b00;
        @(negedge clk);
        check("second_drop", {gnt_o, busy_o}, 3'b000);

        // Requester 1 withdraws during GRANT.
        @(negedge clk);
        req_i = 2'b10; valid_i = 2'b10; data1_i = 8'h3C; phy_ready_i = 1'b1;
        @(negedge clk);
        check("drop_gnt", {gnt_o, phy_oe_o}, {2'b10, 1'b1});
        check("grant_novalid", {phy_valid_o, ready_o}, 3'b000);
        req_i = 2'b00;
        @(negedge clk);
        check("drop_idle", {gnt_o, phy_oe_o, busy_o, phy_valid_o}, 5'b00000);
        valid_i = 2'b00;

        // Reset in the middle of SEND.
        @(negedge clk);
        req_i = 2'b01; valid_i = 2'b01; data0_i = 8'h5A; phy_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_send", {phy_valid_o, phy_oe_o}, 2'b11);
        phy_ready_i = 1'b1; rst_i = 1'b1;
        @(negedge clk);
        check("rst_mid", {gnt_o, ready_o, phy_data_o, phy_valid_o, phy_last_o,
                          phy_oe_o, phy_abort_o, busy_o}, 32'd0);
        rst_i = 1'b0; valid_i = 2'b00;
        @(negedge clk);
        check("post_rst_gnt", gnt_o, 2'b01);
        req_i = 2'b00;
        @(negedge clk);
        check("post_rst_idle", busy_o, 1'b0);
        quiet_inputs();

        for (int i = 0; i < 20; i++) begin
            int nb;
            nb = $urandom_range(1, 6);
            run_packet($urandom_range(0, 1), nb,
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1,
                       $urandom_range(0, 3), $urandom_range(1, 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_tx_arbiter.md
Name: usb_tx_arbiter

Overview:
- Sequences and shares the USB 1.1 physical transfer datapath's transmit side between two byte-stream requesters: requester 0 for handshake/token packets and requester 1 for endpoint data.
- Grants the bus only when the line is not receiving.
- Passes bytes to the PHY and waits for EOP completion.
- Enforces an inter-packet gap before the next grant.
- Aborts stalled packets with a watchdog.

Parameters:
GAP_CLKS, 16, idle clocks held after EOP before next grant (min 1)
MAX_STALL, 64, consecutive SEND clocks with granted valid low before abort (min 2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
req_i  in  2  per-requester packet request, held until its last byte is accepted
data0_i  in  8  requester 0 byte
data1_i  in  8  requester 1 byte
valid_i  in  2  per-requester byte valid
last_i  in  2  per-requester final-byte flag, qualified by valid
ready_o  out  2  per-requester byte accepted (only the granted bit can be high)
gnt_o  out  2  one-hot grant, held GRANT..EOP_WAIT
rx_active_i  in  1  PHY is receiving; blocks new grants
phy_data_o  out  8  byte to PHY
phy_valid_o  out  1  byte valid to PHY
phy_ready_i  in  1  PHY consumed byte
phy_last_o  out  1  final byte; PHY appends EOP
phy_eop_done_i  in  1  one-clock pulse, EOP driven and line back to J
phy_oe_o  out  1  drive enable for dp/dn pads
phy_abort_o  out  1  one-clock pulse: PHY must emit bit-stuff-error/EOP and release
busy_o  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0. State = IDLE, counters = 0, round-robin pointer = 0.
- Reset asserted mid-packet drops the packet with no abort pulse.
- States: IDLE, GRANT, SEND, EOP_WAIT, GAP.
- IDLE:
  - If any req_i bit is high and rx_active_i is low, latch the winner into gnt_o and go to GRANT.
  - Fixed priority: req_i[0] wins.
  - If rx_active_i is high, stay in IDLE regardless of requests.
- GRANT:
  - Lasts one clock; phy_oe_o rises here, giving the PHY one clock of SYNC lead-in.
  - Go to SEND.
  - If the granted req bit has fallen, clear gnt_o and go to IDLE (no EOP, phy_oe_o low next clock).
- SEND, combinational pass-through from the granted requester:
  - phy_data_o, phy_valid_o and phy_last_o follow the granted requester's data/valid/last.
  - ready_o[g] = phy_ready_i.
  - A byte transfers when valid and ready are both high.
  - A transfer with last high moves to EOP_WAIT.
  - rx_active_i is ignored in SEND, since the arbiter owns the bus.
- Stall watchdog (SEND only):
  - The stall counter increments each SEND clock with granted valid low and clears on valid high.
  - Reaching MAX_STALL pulses phy_abort_o for one clock and goes to GAP with gnt_o cleared.
- EOP_WAIT:
  - phy_valid_o = 0; phy_oe_o and gnt_o stay high.
  - On phy_eop_done_i: go to GAP, clear gnt_o and phy_oe_o.
- GAP:
  - The counter loads GAP_CLKS-1 on entry and decrements to 0, then the block returns to IDLE.
  - This gives exactly GAP_CLKS clocks in GAP.
  - Requests arriving in GAP are held off, not lost, because requesters hold req_i.
- Latency: from req_i sampled in IDLE, gnt_o is high at the next edge and the first byte can transfer 2 clocks after the request is sampled.
- Simultaneous events:
  - Both requests high in IDLE: requester 0 wins.
  - A last-byte transfer and watchdog expiry cannot coincide, because a transfer requires valid high.
  - phy_eop_done_i outside EOP_WAIT is ignored.
- Counter widths: $clog2(MAX_STALL+1) and $clog2(GAP_CLKS+1). Counters saturate and never wrap.

Optional Feature:
USB_TX_ARB_RR_EN:
- Defined: round-robin arbitration. A 1-bit pointer selects the preferred requester on simultaneous requests and toggles to the non-granted index after each completed or aborted packet.
- Undefined: fixed priority, requester 0 always wins. No pointer register is built.

Decomposition:
- Package usb_tx_pkg holds:
  - state enum (IDLE, GRANT, SEND, EOP_WAIT, GAP);
  - requester index constants REQ_HS = 0, REQ_DATA = 1;
  - byte width constant 8.
- One natural sub-module: usb_tx_rr_pick, the 2-way priority/round-robin selector producing a one-hot winner from req_i and the pointer.

Test Plan:
- Requester 1 alone sends 0xC3,0x01,0x02 (last on 0x02) with phy_ready_i always high -> gnt_o = 2'b10 one clock after request; three phy transfers; EOP_WAIT until eop pulse; GAP lasts 16 clocks; back to IDLE.
- Both requests raised in the same clock -> gnt_o = 2'b01. With USB_TX_ARB_RR_EN, the second packet grants 2'b10 while requester 0 is still requesting.
- rx_active_i high while req_i = 2'b01 -> no grant until rx_active_i falls; grant the following clock.
- Requester 0 holds valid low for 64 SEND clocks -> phy_abort_o pulses once at the 64th clock; gnt_o clears; GAP entered; no EOP_WAIT.
- req_i[1] dropped during GRANT -> IDLE next clock, phy_oe_o low, no bytes transferred.
- rst_i asserted mid-SEND -> all outputs 0 at the next edge; a new request after reset is granted normally.
